// File: rtl/temp_sensor_reader_pkg.sv
// temp_sensor_reader_pkg: frame layout, output width and FSM states shared by the sensor reader.
package temp_sensor_reader_pkg;

    localparam int TEMPERATURE_SENSOR_DATA_WIDTH = 12;
    localparam int SENSOR_FRAME_BITS             = 16;
    localparam int SENSOR_DATA_MSB               = 14;
    localparam int SENSOR_DATA_LSB               = 3;
    localparam int SENSOR_FAULT_BIT              = 2;
    localparam int SENSOR_ZERO_BIT               = 15;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_LO,
        SHIFT_HI,
        CS_HOLD,
        UPDATE
    } state_e;

    function automatic logic frame_ok(input logic [SENSOR_FRAME_BITS-1:0] frame);
        return !frame[SENSOR_ZERO_BIT] && !frame[SENSOR_FAULT_BIT];
    endfunction

endpackage

// File: rtl/temp_sensor_reader_spi_rx.sv
// sensor_spi_frame_rx: SPI frame sequencer for the temperature sensor; synchronises MISO,
// generates CS/SCLK from registers and shifts in one 16-bit frame per start request.
module sensor_spi_frame_rx
    import temp_sensor_reader_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         miso_i,
    output logic                         sclk_o,
    output logic                         cs_no,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [SENSOR_FRAME_BITS-1:0] frame_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_e                       state_q, state_d;
    logic [DW-1:0]                div_q, div_d;
    logic [4:0]                   bit_q, bit_d;
    logic [SENSOR_FRAME_BITS-1:0] shift_q, shift_d;
    logic [1:0]                   sync_q;
    logic                         sclk_q, cs_q;
    logic                         div_last;

    assign div_last = div_q == DIV_LAST;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = (state_q == IDLE || state_q == UPDATE || div_last) ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CS_SETUP;
                    bit_d   = '0;
                end
            end
            CS_SETUP: state_d = div_last ? SHIFT_LO : state_q;
            SHIFT_LO: state_d = div_last ? SHIFT_HI : state_q;
            SHIFT_HI: begin
                if (div_last) begin
                    shift_d = {shift_q[SENSOR_FRAME_BITS-2:0], sync_q[1]};
                    bit_d   = bit_q + 5'd1;
                    state_d = (bit_q == 5'(SENSOR_FRAME_BITS - 1)) ? CS_HOLD : SHIFT_LO;
                end
            end
            CS_HOLD:  state_d = div_last ? UPDATE : state_q;
            default:  state_d = IDLE;
        endcase
    end

    // CS and SCLK are registered from the next state so both pins are glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sync_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sync_q  <= {sync_q[0], miso_i};
            sclk_q  <= state_d == SHIFT_HI;
            cs_q    <= !(state_d inside {CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD});
        end
    end

    assign sclk_o  = sclk_q;
    assign cs_no   = cs_q;
    assign busy_o  = state_q != IDLE;
    assign done_o  = state_q == UPDATE;
    assign frame_o = shift_q;

endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: periodic SPI temperature reader; validates each frame and holds the
// last good reading on temparature_o for the AC controller.
module temp_sensor_reader
    import temp_sensor_reader_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    input  logic                                     miso_i,
    output logic                                     sclk_o,
    output logic                                     cs_no,
    output logic [TEMPERATURE_SENSOR_DATA_WIDTH-1:0] temparature_o,
    output logic                                     valid_o,
    output logic                                     fault_o,
    output logic                                     busy_o
);

    localparam int PW = $clog2(SAMPLE_PERIOD);

    logic [PW-1:0]                            period_q, period_d, period_inc;
    logic [TEMPERATURE_SENSOR_DATA_WIDTH-1:0] temp_q, temp_d;
    logic                                     valid_q, valid_d, fault_q, fault_d;
    logic                                     go, done, ok;
    logic [SENSOR_FRAME_BITS-1:0]             frame;

    sensor_spi_frame_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (go),
        .miso_i  (miso_i),
        .sclk_o  (sclk_o),
        .cs_no   (cs_no),
        .busy_o  (busy_o),
        .done_o  (done),
        .frame_o (frame)
    );

    assign period_inc = period_q + 1'b1;
    assign ok         = frame_ok(frame);

    // Terminal count after SAMPLE_PERIOD-1 idle cycles, so with UPDATE cs_no idles SAMPLE_PERIOD clocks.
    always_comb begin
        go       = !busy_o && (start_i || period_inc == PW'(SAMPLE_PERIOD - 1));
        period_d = (go || busy_o) ? '0 : period_inc;
        valid_d  = done && ok;
        fault_d  = done ? !ok : fault_q;
        temp_d   = valid_d ? frame[SENSOR_DATA_MSB:SENSOR_DATA_LSB] : temp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            temp_q   <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            temp_q   <= temp_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign temparature_o = temp_q;
    assign valid_o       = valid_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader: directed and randomized frames from a sensor model, checked
// against a frame-level reference of the reading, fault and timing rules.
module tb_temp_sensor_reader;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 100;
    localparam int LAT           = CLK_DIV + 32 * CLK_DIV + CLK_DIV + 1;

    logic        clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, miso_i = 1'b0;
    logic        sclk_o, cs_no, valid_o, fault_o, busy_o;
    logic [11:0] temparature_o;

    temp_sensor_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .miso_i        (miso_i),
        .sclk_o        (sclk_o),
        .cs_no         (cs_no),
        .temparature_o (temparature_o),
        .valid_o       (valid_o),
        .fault_o       (fault_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: frame starts, CS-high gap, SCLK edges and valid pulses per frame.
    int   n_falls = 0, fall_cyc = 0, rise_cyc = 0, gap = 0;
    int   sclk_rises = 0, frame_valids = 0, valid_cyc = 0, total_valids = 0;
    logic cs_prev = 1'b1, sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (cs_prev && !cs_no) begin
            n_falls++;
            gap = cyc - rise_cyc;
            fall_cyc = cyc;
            sclk_rises = 0;
            frame_valids = 0;
        end
        if (!cs_prev && cs_no) rise_cyc = cyc;
        if (!sclk_prev && sclk_o) sclk_rises++;
        if (valid_o) begin
            frame_valids++;
            total_valids++;
            valid_cyc = cyc;
        end
        cs_prev = cs_no;
        sclk_prev = sclk_o;
    end

    // Sensor: presents MSB on CS fall, next bit on each SCLK fall.
    logic [15:0] next_word = 16'h0, cur_word = 16'h0;
    int idx = 0;
    always @(negedge cs_no) begin
        cur_word = next_word;
        idx = 15;
        miso_i = next_word[15];
    end
    always @(negedge sclk_o) begin
        if (!cs_no && idx > 0) begin
            idx--;
            miso_i = cur_word[idx];
        end
    end

    // Reference: what the downstream consumer should see after a frame carrying w.
    logic [11:0] exp_temp = 12'h0;
    logic        exp_fault = 1'b0;
    int          exp_valid = 0;
    task automatic model(input logic [15:0] w);
        if (!w[15] && !w[2]) begin
            exp_temp = w[14:3];
            exp_fault = 1'b0;
            exp_valid = 1;
        end else begin
            exp_fault = 1'b1;
            exp_valid = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(input int target, input int budget);
        int k = 0;
        while (n_falls < target && k < budget) begin
            step();
            k++;
        end
        check("cs_fall_timeout", 32'(n_falls >= target), 1);
    endtask

    task automatic wait_sclk(input int n);
        int k = 0;
        while (sclk_rises < n && k < 300) begin
            step();
            k++;
        end
        check("sclk_timeout", 32'(sclk_rises >= n), 1);
    endtask

    task automatic start_frame(input logic [15:0] w);
        int f0, c0;
        next_word = w;
        f0 = n_falls;
        c0 = cyc;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("start_next_cycle", 32'((n_falls == f0 + 1) && (fall_cyc == c0 + 1)), 1);
    endtask

    task automatic finish_frame(input logic [15:0] w);
        int k = 0;
        while (busy_o !== 1'b0 && k < 200) begin
            step();
            k++;
        end
        check("busy_falls", 32'(busy_o), 0);
        model(w);
        check("temperature", 32'(temparature_o), 32'(exp_temp));
        check("fault", 32'(fault_o), 32'(exp_fault));
        check("valid_pulses", frame_valids, exp_valid);
        check("sclk_rises", sclk_rises, 16);
        if (exp_valid == 1) check("latency", valid_cyc - fall_cyc, LAT);
    endtask

    initial begin
        logic [15:0] w;
        int f0, v0, k;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs", 32'(cs_no), 1);
        check("rst_sclk", 32'(sclk_o), 0);
        check("rst_temp", 32'(temparature_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst_ni = 1'b1;
        step();

        start_frame(16'h0C80);
        finish_frame(16'h0C80);
        check("temp_100C", 32'(temparature_o), 32'h190);
        start_frame(16'h0004);
        finish_frame(16'h0004);
        check("open_sensor_hold", 32'(temparature_o), 32'h190);
        start_frame(16'h0008);
        finish_frame(16'h0008);
        check("temp_one_lsb", 32'(temparature_o), 32'h001);
        start_frame(16'hFFFF);
        finish_frame(16'hFFFF);
        start_frame(16'h0000);
        finish_frame(16'h0000);
        check("zero_frame_fault", 32'(fault_o), 0);

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            if (i % 2 == 0) w = w & 16'h7FFB;
            start_frame(w);
            finish_frame(w);
        end

        // Free-running cadence; start_i during the shift phase must be dropped.
        w = 16'($urandom) & 16'h7FFB;
        next_word = w;
        f0 = n_falls;
        wait_fall(f0 + 1, 200);
        check("gap_free_run", gap, SAMPLE_PERIOD);
        wait_sclk(3);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_sclk(10);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        finish_frame(w);
        check("busy_start_ignored", n_falls, f0 + 1);
        wait_fall(f0 + 2, 200);
        check("gap_after_ignored", gap, SAMPLE_PERIOD);
        finish_frame(w);

        // start_i coinciding with the period terminal count.
        w = 16'($urandom) & 16'h7FFB;
        next_word = w;
        f0 = n_falls;
        k = 0;
        while (cyc < rise_cyc + SAMPLE_PERIOD - 1 && k < 200) begin
            step();
            k++;
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("tc_start_one_frame", n_falls, f0 + 1);
        check("tc_start_gap", gap, SAMPLE_PERIOD);
        finish_frame(w);
        wait_fall(f0 + 2, 200);
        check("tc_next_gap", gap, SAMPLE_PERIOD);
        finish_frame(w);

        // Reset in the middle of the frame.
        start_frame(16'h0C80);
        wait_sclk(7);
        v0 = total_valids;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_cs", 32'(cs_no), 1);
        check("mid_rst_sclk", 32'(sclk_o), 0);
        check("mid_rst_temp", 32'(temparature_o), 0);
        check("mid_rst_fault", 32'(fault_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        exp_temp = 12'h0;
        exp_fault = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        k = 0;
        while (cs_no && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("restart_delay", 32'(k >= SAMPLE_PERIOD - 1 && k <= SAMPLE_PERIOD), 1);
        check("no_partial_publish", total_valids, v0);
        finish_frame(16'h0C80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
